// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// the FSM state type, the datapath width, and the operand magnitude / negate
// helpers. The helpers are pure functions, so the ALU can reuse them.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Absolute value when the operand is treated as signed. 0x80000000 maps
    // to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag_word(input logic [XLEN-1:0] x,
                                                 input logic is_signed);
        return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit in EX. Operates on operand magnitudes
// (shift-add multiply, restoring divide, 32 iterations) and applies the sign
// on the way into result_o. Holds the pipeline with stall_o while busy.
//
// Ports:
//   clk, rstn         clock, async active-low reset
//   start_i           ID/EX holds an M-extension op (level, held while stalled)
//   op_i              funct3
//   a_i, b_i          forwarded rs1 / rs2
//   flush_i           abort current operation, return to IDLE
//   stall_o           hold ID/EX and upstream
//   done_o            result_o valid this cycle
//   result_o          final result, held until the next accepted start
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; special divide cases resolved here
// CALC    | 32 iterations, one multiplier bit / quotient bit per cycle
// DONE    | result_o valid for one cycle, pipeline released
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    import muldiv_pkg::*;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     mag_b_q;
    // Multiply: {partial high word, multiplier shifting out}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     result_q;

    logic                a_signed, b_signed, sa, sb, sign_in;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [2*XLEN-1:0]   mul_step, div_step, acc_step, prod_signed;
    logic [XLEN-1:0]     div_raw, div_res, final_res;

    // ---------------- operand decode in IDLE ----------------
    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        sa       = a_signed & a_i[XLEN-1];
        sb       = b_signed & b_i[XLEN-1];
        sign_in  = (op_i == OP_REM) ? sa : (sa ^ sb);

        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        special  = div_zero || div_ovf;

        // op_i[1] selects remainder for the divide group.
        if (div_zero)
            special_res = op_i[1] ? a_i : '1;
        else
            special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---------------- one iteration ----------------
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};

        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mag_b_q};
        div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        acc_step  = op_q[2] ? div_step : mul_step;

        // High-word products need the full 64-bit negate to get the borrow right.
        prod_signed = neg_q ? neg_dword(acc_step) : acc_step;
        div_raw     = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        div_res     = neg_q ? neg_word(div_raw) : div_raw;

        if (op_q[2])
            final_res = div_res;
        else if (op_q == OP_MUL)
            final_res = prod_signed[XLEN-1:0];
        else
            final_res = prod_signed[2*XLEN-1:XLEN];
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == '1) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i)
            state_d = ST_IDLE;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (!flush_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            op_q    <= op_i;
                            neg_q   <= sign_in;
                            mag_b_q <= mag_word(b_i, b_signed);
                            acc_q   <= {{XLEN{1'b0}}, mag_word(a_i, a_signed)};
                            cnt_q   <= '0;
                            if (special)
                                result_q <= special_res;
                        end
                    end
                    ST_CALC: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1)
                            result_q <= final_res;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stall_o  = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_CALC);
    assign done_o   = (state_q == ST_DONE) && !flush_i;
    assign result_o = result_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded source operands and the M-extension function code of the instruction held in ID/EX. It computes the result over multiple cycles and holds the ID/EX register and all upstream stages with `stall_o` until the result is ready. The result is muxed into the EX answer path (CCU-EX) in the cycle `done_o` is high.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `CNT_W`, default 5: iteration counter width, equal to log2(XLEN).

- `clk` in 1: pipeline clock.
- `rstn` in 1: asynchronous reset, active-low.
- `start_i` in 1: the ID/EX instruction is an M-extension op. Level signal, held while stalled.
- `op_i` in 3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a_i` in 32: rs1 operand, after forwarding.
- `b_i` in 32: rs2 operand, after forwarding.
- `flush_i` in 1: branch/trap flush of EX; aborts the current operation.
- `stall_o` out 1: hold ID/EX and upstream stages.
- `done_o` out 1: `result_o` is valid this cycle.
- `result_o` out 32: final result; held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, `start_i`=1, `flush_i`=0:
  - Latch `op_i`.
  - Latch the magnitudes of the operands. Signed: a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM.
  - Latch the result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clear the counter; go to CALC.
- Special divide cases skip CALC and go IDLE→DONE with a precomputed result:
  - b=0: quotient = 0xFFFFFFFF; remainder = a_i.
  - Signed a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle; 32-bit remainder, 33-bit trial subtract.
- CALC ends after exactly 32 cycles (counter 0..31); then DONE.
- Result sign fixup is a two's-complement negate when the latched sign is 1, registered into `result_o` on entry to DONE.
  - MUL takes the low word of the product; MULH/MULHSU/MULHU take the high word.
  - Zero results are never negated.
- DONE: `done_o`=1 for one cycle, then IDLE unconditionally. `start_i` is ignored in DONE, because the same instruction is still presented that cycle.
- `flush_i`=1 in any state: go to IDLE next edge, `done_o`=0, `result_o` unchanged. `flush_i` has priority over `start_i`.
- Reset values: state IDLE, counter 0, accumulators 0, `result_o`=0, `done_o`=0. `stall_o`=0 because it is derived from state IDLE with `start_i` low.

## Timing
- `stall_o` is combinational: (IDLE & `start_i` & ~`flush_i`) | CALC. It is low in DONE, so the pipeline advances on the DONE edge and captures `result_o`.
- Normal op with start sampled at edge 0:
  - CALC occupies cycles 1–32.
  - DONE is cycle 33 (`done_o` high).
  - Stall cycles: 33 (cycles 0–32).
- Special divide: DONE in cycle 1; stall cycles: 1.
- Back-to-back M ops: the second is accepted in the IDLE cycle following DONE.
- Reset asserted mid-CALC: all state returns to reset values immediately; no `done_o`.

## Structure
- Shared package `muldiv_pkg` holds:
  - the funct3 op encodings (`OP_MUL` … `OP_REMU`);
  - the FSM state enum (2-bit);
  - `XLEN`.
- Single module; no sub-module. Operand magnitude and negate logic are inline functions in `muldiv_pkg`, reusable by the ALU.
- Expected size: ~200 lines of RTL.

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result_o`=0xFFFFFFEB in cycle 33; `stall_o` high for cycles 0–32.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Divide by zero and overflow:
  - DIVU 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234; both with `done_o` in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- `flush_i` asserted in CALC cycle 10 → IDLE next cycle; `done_o` never asserted; `result_o` keeps its prior value. A new MUL 3×4 then yields 12.
- `rstn` low in CALC cycle 20 → `stall_o`=0, `result_o`=0, `done_o`=0 immediately. After release, DIV 9/3 → 3 in cycle 33.
